// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART RX frame FSM, deserializer and parity/stop qualification
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  input  logic                  par_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  parity_check_en,
  output logic                  par_typ_o,
  output logic                  data_valid,
  output logic                  par_err_o,
  output logic                  stop_err_o
);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q;
  logic par_en_q, perr_q, bit_end, stop_end, start_det;
  assign bit_end   = (state_q != IDLE) && (edge_cnt == Prescale - PRESCALE_W'(1));
  assign stop_end  = (state_q == STOP) && bit_end;
  assign start_det = (state_q == IDLE) && !RX_IN;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RX_IN ? IDLE : START;
      START:   state_d = bit_end ? (sampled_bit ? IDLE : DATA) : START;
      DATA:    state_d = (bit_end && bit_cnt_q == BW'(DATA_WIDTH-1)) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = bit_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // Strobe outputs follow the next state so they line up with state_q one cycle later
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      bit_cnt_q       <= '0;
      par_en_q        <= 1'b0;
      perr_q          <= 1'b0;
      dat_samp_en     <= 1'b0;
      edge_cnt        <= '0;
      P_data          <= '0;
      parity_check_en <= 1'b0;
      par_typ_o       <= 1'b0;
      data_valid      <= 1'b0;
      par_err_o       <= 1'b0;
      stop_err_o      <= 1'b0;
    end else begin
      state_q         <= state_d;
      dat_samp_en     <= state_d != IDLE;
      parity_check_en <= state_d == PARITY;
      edge_cnt        <= (state_q == IDLE || bit_end) ? '0 : edge_cnt + PRESCALE_W'(1);
      data_valid      <= stop_end && sampled_bit && !perr_q;
      par_err_o       <= stop_end && perr_q;
      stop_err_o      <= stop_end && !sampled_bit;
      if (start_det) begin
        par_en_q  <= PAR_EN;
        par_typ_o <= PAR_TYP;
        perr_q    <= 1'b0;
        P_data    <= '0;
      end
      if (state_q == START && bit_end) bit_cnt_q <= '0;
      if (state_q == DATA && bit_end) begin
        P_data    <= {sampled_bit, P_data[DATA_WIDTH-1:1]};
        bit_cnt_q <= bit_cnt_q + BW'(1);
      end
      if (state_q == PARITY && bit_end) perr_q <= par_err;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed and random frames checked against a frame-level scoreboard
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;
  logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0, sampled_bit = 1'b0;
  logic par_err;
  logic [5:0] Prescale = 6'd8;
  logic dat_samp_en, parity_check_en, par_typ_o, data_valid, par_err_o, stop_err_o;
  logic [5:0] edge_cnt;
  logic [7:0] P_data;
  int cyc = 0, n_vec = 0, n_err = 0;
  typedef struct {int cyc; bit v; bit pe; bit se; logic [7:0] d;} ev_t;
  ev_t exp_q[$];

  uart_rx_frame_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .sampled_bit(sampled_bit), .par_err(par_err), .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt),
    .P_data(P_data), .parity_check_en(parity_check_en), .par_typ_o(par_typ_o),
    .data_valid(data_valid), .par_err_o(par_err_o), .stop_err_o(stop_err_o)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Parity checker stand-in: error when word, parity bit and type do not agree
  assign par_err = parity_check_en & (^P_data ^ sampled_bit ^ par_typ_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({dat_samp_en, edge_cnt, P_data, parity_check_en, par_typ_o, data_valid, par_err_o, stop_err_o}), 32'(0));
  endtask

  always @(negedge CLK) begin : mon
    ev_t e;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("data_valid", 32'(data_valid), 32'(e.v));
      check("par_err_o", 32'(par_err_o), 32'(e.pe));
      check("stop_err_o", 32'(stop_err_o), 32'(e.se));
      check("P_data", 32'(P_data), 32'(e.d));
    end else if (!RST && (data_valid || par_err_o || stop_err_o))
      check("spurious_pulse", 32'({data_valid, par_err_o, stop_err_o}), 32'(0));
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      sampled_bit = 1'($urandom);
      @(negedge CLK);
      check("idle_dat_samp_en", 32'(dat_samp_en), 32'(0));
      check("idle_edge_cnt", 32'(edge_cnt), 32'(0));
      @(posedge CLK); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int P, input bit pe, input bit pt,
                            input bit bad_par, input bit bad_stop, input bit glitch, input int abort);
    logic [11:0] bits;
    int nb, n0, q, k, e;
    nb = glitch ? 1 : 10 + int'(pe);
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pe) bits[9] = ^d ^ pt ^ bad_par;
    if (!glitch) bits[nb-1] = !bad_stop;
    n0 = cyc;
    Prescale = 6'(P);
    PAR_EN = pe;
    PAR_TYP = pt;
    if (!glitch && abort < 0)
      exp_q.push_back('{cyc: n0 + 1 + nb * P, v: !(pe && bad_par) && !bad_stop, pe: pe && bad_par, se: bad_stop, d: d});
    for (int p = 0; p <= nb * P; p++) begin
      RX_IN = glitch ? (p >= 3) : ((p / P < nb) ? bits[p / P] : 1'b1);
      q = p - 1;
      k = q / P;
      e = q % P;
      sampled_bit = (q >= 0 && e >= P / 2 + 2) ? (glitch ? 1'b1 : bits[k]) : 1'($urandom);
      if (p > 0) begin
        PAR_EN = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
      RST = (p == abort);
      @(negedge CLK);
      check("dat_samp_en", 32'(dat_samp_en), 32'(p > 0));
      check("edge_cnt", 32'(edge_cnt), (p > 0) ? 32'((p - 1) % P) : 32'(0));
      check("parity_check_en", 32'(parity_check_en), 32'(p > 0 && pe && (p - 1) / P == 9));
      if (p == 1) check("par_typ_o", 32'(par_typ_o), 32'(pt));
      @(posedge CLK); #1;
      if (p == abort) begin
        RST = 1'b0;
        check_zero("reset_mid_frame");
        return;
      end
    end
  endtask

  initial begin
    bit pe, pt, bp, bs, gl;
    int P;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 1'b0;
    idle(2);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    idle(3);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    send_frame(8'h55, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(2);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(2);
    send_frame(8'h9E, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1 + 5 * 8 + 3);
    send_frame(8'h12, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h34, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'hC3, 32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    repeat (24) begin
      P  = 8 << $urandom_range(0, 2);
      pe = 1'($urandom);
      pt = 1'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 4) == 0);
      gl = ($urandom_range(0, 7) == 0);
      send_frame(8'($urandom), P, pe, pt, bp, bs, gl, -1);
      idle($urandom_range(0, 3));
    end
    idle(8);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
